mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
Memory-port controller sitting directly upstream of the shared ram block. It accepts single-word load/store requests from the processor datapath over a valid/ready handshake. It drives the RAM's addr/rdEn/wrEn lines and its bidirectional tri-state data bus, and returns read data or a write acknowledge on a one-cycle response strobe. It guarantees bus turnaround, mutual exclusion of rdEn/wrEn, and range checking.

Parameters:
DEPTH, 2**AWIDTH, number of implemented RAM words; addresses >= DEPTH are out of range
RD_LAT, 1, cycles after rdEn is first sampled before RAM read data is valid on the bus (range 0..7)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  AWIDTH  word address
req_wdata  input  DWIDTH  store data
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  DWIDTH  load data; valid with resp_valid on loads
resp_err  output  1  with resp_valid: address out of range
data  inout  DWIDTH  RAM data bus; driven only while wrEn=1, else all Z
addr  output  AWIDTH  RAM address
rdEn  output  1  RAM read enable
wrEn  output  1  RAM write enable

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs are registered; data is driven from a registered value gated by registered wrEn.
- Reset values: req_ready=0 during the reset cycle and 1 afterwards. resp_valid=0, resp_err=0, resp_rdata=0, addr=0, rdEn=0, wrEn=0, data=Z, state=IDLE, last_rd=0.
- Handshake: a request transfers on an edge where req_valid && req_ready. req_addr, req_we and req_wdata are latched on that edge. req_ready=1 only in IDLE. Request inputs are ignored otherwise.
- FSM states: IDLE, TURN, WRITE, READ, ERR.
- IDLE, on transfer:
  - addr >= DEPTH -> ERR.
  - Store with last_rd=1 -> TURN.
  - Other store -> WRITE.
  - Load -> READ.
- ERR: one cycle, no RAM activity. Then resp_valid=1, resp_err=1, resp_rdata=0, -> IDLE.
- TURN: one cycle with rdEn=wrEn=0 and bus Z. Clears last_rd, -> WRITE.
- WRITE: exactly one cycle with wrEn=1, addr=latched address, data=latched wdata. The RAM captures at the edge ending this cycle. The next cycle has wrEn=0, bus Z, resp_valid=1, resp_err=0; resp_rdata holds its previous value. -> IDLE.
- READ: rdEn=1 and addr held for RD_LAT+1 cycles, with a 3-bit down-counter. data is sampled into resp_rdata on the edge ending the last rdEn cycle. The next cycle has rdEn=0, resp_valid=1, resp_err=0, last_rd=1. -> IDLE.
- Latency from accept edge to resp_valid: load = RD_LAT+2 cycles; store = 2 cycles (3 with TURN); error = 2 cycles.
- IDLE accepts a new request in the same cycle resp_valid is high. Back-to-back stores therefore issue wrEn every other cycle.
- last_rd is cleared by any accepted store or error. A load following a load needs no turnaround.
- Invariants, checked every cycle:
  - never rdEn && wrEn;
  - data != Z only when wrEn=1;
  - resp_valid is never high for two consecutive cycles of the same request.
- Reset mid-operation: at the next edge, all outputs return to reset values and the pending request is dropped with no resp_valid. The bus is released in the cycle after reset is sampled.
- resp_valid is not backpressured: the consumer must take it.

Decomposition:
- Shared InstructionStruct package: DWIDTH and AWIDTH stay as the shared width constants. Add typedef enum mem_ctrl_state_t {IDLE, TURN, WRITE, READ, ERR} there for bench visibility.
- No sub-module. The latency counter and tri-state driver are inline, and the block is a single FSM.

Test Plan:
- Reset, then store 0xA5 @addr 3 -> wrEn=1 for exactly one cycle with data=0xA5 and addr=3. resp_valid 2 cycles after accept with resp_err=0. Bus Z afterwards.
- Load @addr 3 after that store (RD_LAT=1) -> rdEn high 2 cycles, resp_valid 3 cycles after accept, resp_rdata=0xA5, no TURN cycle inserted.
- Load @1 then immediately store 0x3C @1 -> one idle TURN cycle (rdEn=wrEn=0, bus Z) between rdEn falling and wrEn rising. A subsequent load @1 returns 0x3C.
- req_addr = DEPTH (with DEPTH=8, addr 8) -> no rdEn/wrEn ever. resp_valid=1, resp_err=1, resp_rdata=0 two cycles after accept.
- Assert reset during the second rdEn cycle of a load -> rdEn=0 at the next edge, no resp_valid, req_ready=1 one cycle after reset deasserts. A fresh load then completes normally.
- Random mix of 200 loads/stores against a bench memory model, with req_valid toggled randomly -> all read data matches the model. The rdEn&&wrEn and bus-contention assertions never fire.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared width constants and state encoding for the memory-port controller.
package mem_bus_ctrl_pkg;

    localparam int AWIDTH = 4;
    localparam int DWIDTH = 8;

    // Controller FSM states; exported so the bench can watch the sequencer.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TURN  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        ERR   = 3'd4
    } mem_ctrl_state_t;

    // True when a word address falls inside the implemented RAM.
    function automatic logic addr_in_range(input logic [AWIDTH-1:0] a,
                                           input int unsigned     depth);
        return (32'(a) < depth);
    endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Memory-port controller: single-word load/store requests in, RAM
// addr/rdEn/wrEn and tri-state data bus out, one-cycle response strobe back.
//
// Request handshake: a request transfers on a rising edge where
// req_valid && req_ready; req_we/req_addr/req_wdata are captured on that
// edge and ignored at all other times. resp_valid is a one-cycle pulse with
// no backpressure.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int DEPTH  = 2**AWIDTH,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              resp_err,
    inout  wire  [DWIDTH-1:0] data,
    output logic [AWIDTH-1:0] addr,
    output logic              rdEn,
    output logic              wrEn,
    output mem_ctrl_state_t   state,
    output logic              last_rd
);

    // rdEn stays high for RD_LAT+1 cycles; the counter starts at RD_LAT and
    // the bus is sampled when it has reached zero.
    localparam logic [2:0] RD_CNT_INIT = 3'(RD_LAT);

    mem_ctrl_state_t   state_q,      state_next;
    logic [2:0]        lat_cnt_q,    lat_cnt_next;
    logic              last_rd_q,    last_rd_next;
    logic [AWIDTH-1:0] addr_q,       addr_next;
    logic [DWIDTH-1:0] wdata_q,      wdata_next;
    logic              rd_en_q,      rd_en_next;
    logic              wr_en_q,      wr_en_next;
    logic              req_ready_q,  req_ready_next;
    logic              resp_valid_q, resp_valid_next;
    logic              resp_err_q,   resp_err_next;
    logic [DWIDTH-1:0] resp_rdata_q, resp_rdata_next;
    logic              accept;

    assign accept = req_valid && req_ready_q;

    // Next-state and next-output decode; every output is registered from here.
    always_comb begin
        state_next      = state_q;
        lat_cnt_next    = lat_cnt_q;
        last_rd_next    = last_rd_q;
        addr_next       = addr_q;
        wdata_next      = wdata_q;
        rd_en_next      = 1'b0;
        wr_en_next      = 1'b0;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rdata_next = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_next  = req_addr;
                    wdata_next = req_wdata;
                    if (!addr_in_range(req_addr, DEPTH)) begin
                        // Out-of-range: no RAM activity, just report.
                        state_next   = ERR;
                        last_rd_next = 1'b0;
                    end else if (req_we) begin
                        last_rd_next = 1'b0;
                        if (last_rd_q) begin
                            // RAM may still be releasing the bus after a read.
                            state_next = TURN;
                        end else begin
                            state_next = WRITE;
                            wr_en_next = 1'b1;
                        end
                    end else begin
                        state_next   = READ;
                        rd_en_next   = 1'b1;
                        lat_cnt_next = RD_CNT_INIT;
                    end
                end
            end
            TURN: begin
                state_next   = WRITE;
                wr_en_next   = 1'b1;
                last_rd_next = 1'b0;
            end
            WRITE: begin
                // RAM captured at the edge ending the wrEn cycle.
                state_next      = IDLE;
                resp_valid_next = 1'b1;
            end
            READ: begin
                if (lat_cnt_q == 3'd0) begin
                    state_next      = IDLE;
                    resp_valid_next = 1'b1;
                    resp_rdata_next = data;
                    last_rd_next    = 1'b1;
                end else begin
                    lat_cnt_next = lat_cnt_q - 3'd1;
                    rd_en_next   = 1'b1;
                end
            end
            ERR: begin
                state_next      = IDLE;
                resp_valid_next = 1'b1;
                resp_err_next   = 1'b1;
                resp_rdata_next = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Ready only while the controller sits in IDLE.
        req_ready_next = (state_next == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            last_rd_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_next;
            lat_cnt_q    <= lat_cnt_next;
            last_rd_q    <= last_rd_next;
            addr_q       <= addr_next;
            wdata_q      <= wdata_next;
            rd_en_q      <= rd_en_next;
            wr_en_q      <= wr_en_next;
            req_ready_q  <= req_ready_next;
            resp_valid_q <= resp_valid_next;
            resp_err_q   <= resp_err_next;
            resp_rdata_q <= resp_rdata_next;
        end
    end

    // Bus is driven only from the registered write data while wrEn is high.
    assign data = wr_en_q ? wdata_q : {DWIDTH{1'bz}};

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign addr       = addr_q;
    assign rdEn       = rd_en_q;
    assign wrEn       = wr_en_q;
    assign state      = state_q;
    assign last_rd    = last_rd_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl with a RAM model on the shared bus.
module tb_mem_bus_ctrl;
    import mem_bus_ctrl_pkg::*;

    localparam int DEPTH  = 8;
    localparam int RD_LAT = 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0;
    logic              req_we    = 1'b0;
    logic [AWIDTH-1:0] req_addr  = '0;
    logic [DWIDTH-1:0] req_wdata = '0;
    logic              req_ready;
    logic              resp_valid;
    logic [DWIDTH-1:0] resp_rdata;
    logic              resp_err;
    wire  [DWIDTH-1:0] data_bus;
    logic [AWIDTH-1:0] addr;
    logic              rdEn;
    logic              wrEn;
    mem_ctrl_state_t   state;
    logic              last_rd;

    mem_bus_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .data(data_bus), .addr(addr), .rdEn(rdEn), .wrEn(wrEn),
        .state(state), .last_rd(last_rd)
    );

    int   cyc = 0;
    logic rst_at_edge = 1'b1;
    bit   mon_en = 1'b0;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    // ---------------- RAM model ----------------
    // Drives 0 when idle, poison 8'hEE before read data is due, mem word after.
    logic [DWIDTH-1:0] ram [16];
    logic [2:0]        rd_cnt = '0;
    logic [DWIDTH-1:0] ram_drv;

    always @(posedge clk) begin
        if (reset && !mon_en) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'(i * 37 + 11);
        end else if (wrEn) begin
            ram[addr] <= data_bus;
        end
        rd_cnt <= rdEn ? rd_cnt + 3'd1 : 3'd0;
    end

    always_comb begin
        ram_drv = '0;
        if (rdEn) ram_drv = (32'(rd_cnt) >= RD_LAT) ? ram[addr] : 8'hEE;
    end

    assign data_bus = wrEn ? {DWIDTH{1'bz}} : ram_drv;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [24:0]       exp_q[$];   // {due_cycle[15:0], err, rdata}
    logic [11:0]       wr_q[$];    // {addr, data}
    logic [DWIDTH-1:0] model_mem [16];
    logic [DWIDTH-1:0] model_rdata = '0;
    bit                model_last_rd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic we, input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] wd);
        int lat;
        logic err;
        if (32'(a) >= DEPTH) begin
            lat = 2; err = 1'b1; model_rdata = '0; model_last_rd = 1'b0;
        end else if (we) begin
            lat = model_last_rd ? 3 : 2; err = 1'b0;
            model_mem[a] = wd; wr_q.push_back({a, wd}); model_last_rd = 1'b0;
        end else begin
            lat = RD_LAT + 2; err = 1'b0;
            model_rdata = model_mem[a]; model_last_rd = 1'b1;
        end
        exp_q.push_back({16'(cyc + lat), err, model_rdata});
    endtask

    // ---------------- monitors ----------------
    bit prev_wr = 1'b0;
    bit prev_rd = 1'b0;
    bit prev_resp = 1'b0;
    int rd_run = 0;
    always @(negedge clk) begin
        logic [24:0] e;
        logic [11:0] w;
        if (mon_en) begin
            chk("rd_wr_exclusive", 32'(rdEn && wrEn), 0);
            if (!wrEn && !rdEn) chk("bus_released", 32'(data_bus), 0);
            if (req_ready) chk("ready_only_idle", 32'(state), 32'(IDLE));
            if (prev_resp) chk("resp_not_double", 32'(resp_valid), 0);
            if (wrEn) begin
                chk("wr_single_cycle", 32'(prev_wr), 0);
                chk("wr_addr_range", 32'(32'(addr) < DEPTH), 1);
                if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(addr), 32'(w[11:8]));
                    chk("wr_data", 32'(data_bus), 32'(w[7:0]));
                end
            end
            if (rdEn) begin
                chk("rd_addr_range", 32'(32'(addr) < DEPTH), 1);
                rd_run++;
            end else begin
                if (prev_rd && !rst_at_edge) chk("rd_run_len", 32'(rd_run), 32'(RD_LAT + 1));
                rd_run = 0;
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", 32'(resp_rdata), 32'(e[7:0]));
                    chk("resp_err", 32'(resp_err), 32'(e[8]));
                    chk("resp_latency", 32'(16'(cyc)), 32'(e[24:9]));
                end
            end
        end
        prev_wr   = wrEn;
        prev_rd   = rdEn;
        prev_resp = resp_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic we, input logic [AWIDTH-1:0] a,
                        input logic [DWIDTH-1:0] wd, input bit rnd);
        int guard = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (req_ready && (!rnd || $urandom_range(0, 2) != 0)) begin
                req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
                push_exp(we, a, wd);
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                done = 1'b1;
            end else begin
                // Garbage while busy is offered with random valid; never while ready.
                req_valid = (rnd && !req_ready) ? 1'($urandom_range(0, 1)) : 1'b0;
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = 4'($urandom_range(0, 15));
                req_wdata = 8'($urandom);
                guard++;
                if (guard > 60) begin
                    chk("send_timeout", 1, 0);
                    req_valid = 1'b0;
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) chk("resp_timeout", 32'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = 8'(i * 37 + 11);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_resp_rdata", 32'(resp_rdata), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_rdEn", 32'(rdEn), 0);
        chk("rst_wrEn", 32'(wrEn), 0);
        chk("rst_state", 32'(state), 32'(IDLE));
        chk("rst_last_rd", 32'(last_rd), 0);
        chk("rst_bus", 32'(data_bus), 0);
        mon_en = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 1);

        // Store 0xA5 @3
        send(1'b1, 4'd3, 8'hA5, 1'b0);
        @(negedge clk);
        chk("st_wrEn", 32'(wrEn), 1);
        chk("st_addr", 32'(addr), 3);
        chk("st_data", 32'(data_bus), 32'h A5);
        @(negedge clk);
        chk("st_wrEn_drop", 32'(wrEn), 0);
        chk("st_resp", 32'(resp_valid), 1);
        wait_idle();

        // Load @3, no turnaround needed
        send(1'b0, 4'd3, 8'h00, 1'b0);
        @(negedge clk);
        chk("ld_rdEn", 32'(rdEn), 1);
        chk("ld_state", 32'(state), 32'(READ));
        wait_idle();

        // Load @1 then store 0x3C @1 -> TURN cycle
        send(1'b0, 4'd1, 8'h00, 1'b0);
        send(1'b1, 4'd1, 8'h3C, 1'b0);
        @(negedge clk);
        chk("turn_state", 32'(state), 32'(TURN));
        chk("turn_rdEn", 32'(rdEn), 0);
        chk("turn_wrEn", 32'(wrEn), 0);
        @(negedge clk);
        chk("turn_then_wr", 32'(wrEn), 1);
        chk("turn_wr_data", 32'(data_bus), 32'h3C);
        wait_idle();
        send(1'b0, 4'd1, 8'h00, 1'b0);
        wait_idle();

        // Out-of-range address
        send(1'b0, 4'(DEPTH), 8'h00, 1'b0);
        @(negedge clk);
        chk("err_state", 32'(state), 32'(ERR));
        chk("err_no_rd", 32'(rdEn), 0);
        chk("err_no_wr", 32'(wrEn), 0);
        wait_idle();

        // Reset during the second rdEn cycle of a load
        send(1'b0, 4'd3, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rd_second", 32'(rdEn), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdEn", 32'(rdEn), 0);
        chk("mid_rst_resp", 32'(resp_valid), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        chk("mid_rst_state", 32'(state), 32'(IDLE));
        exp_q.delete();
        wr_q.delete();
        model_rdata   = '0;
        model_last_rd = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_back", 32'(req_ready), 1);
        chk("mid_rst_no_resp", 32'(resp_valid), 0);
        send(1'b0, 4'd3, 8'h00, 1'b0);
        wait_idle();

        // Random mix of loads/stores with toggling req_valid
        for (int n = 0; n < 200; n++) begin
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 8'($urandom), 1'b1);
        end
        wait_idle();
        chk("final_exp_q_empty", 32'(exp_q.size()), 0);
        chk("final_wr_q_empty", 32'(wr_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
